// File: rtl/src_control_unit.sv
// Hardwired control sequencer for the Mini SRC bus datapath: fetch (T0-T2)
// and register-register ALU execute (T3-T6), with run/stop/halt and a retire counter.
module src_control_unit #(
  parameter int CNT_W = 16,
  parameter int NREG  = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [NREG-1:0]  R_in,
  output logic [NREG-1:0]  R_out,
  output logic [3:0]       alu_op,
  output logic             running,
  output logic             halted,
  output logic             illegal_op,
  output logic [2:0]       step,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state, state_nxt;
  logic   pc_loaded;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_halt, is_legal, is_muldiv, is_unary, retire;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_halt   = (opcode == 5'd31);
  assign is_legal  = (opcode <= 5'd11);
  assign is_muldiv = (opcode == 5'd8) || (opcode == 5'd9);
  assign is_unary  = (opcode == 5'd10) || (opcode == 5'd11);
  assign retire    = ((state == S_T5) && !is_muldiv) || (state == S_T6);

  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= S_IDLE;
      pc_loaded   <= 1'b0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state     <= state_nxt;
      // PC is loaded only on the first T1 cycle even when T1 stretches for memory
      pc_loaded <= (state == S_T1);
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
      if ((state == S_T3) && !is_halt && !is_legal)
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = (is_halt || !is_legal) ? S_HALT : S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = is_muldiv ? S_T6 : (stop ? S_IDLE : S_T0);
      S_T6:   state_nxt = stop ? S_IDLE : S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    R_in = '0; R_out = '0; alu_op = 4'd0; step = 3'd0;
    running = 1'b0; halted = 1'b0;
    case (state)
      S_T0: begin
        running = 1'b1; step = 3'd0;
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        running = 1'b1; step = 3'd1;
        Zlowout = 1'b1; Read = 1'b1;
        PCin = !pc_loaded; MDRin = mem_ready;
      end
      S_T2: begin
        running = 1'b1; step = 3'd2;
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        running = 1'b1; step = 3'd3;
        if (is_legal) begin
          R_out = reg_sel(rb); Yin = 1'b1;
        end
      end
      S_T4: begin
        running = 1'b1; step = 3'd4;
        alu_op = opcode[3:0]; Zin = 1'b1;
        R_out = is_unary ? reg_sel(rb) : reg_sel(rc);
      end
      S_T5: begin
        running = 1'b1; step = 3'd5;
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           R_in = reg_sel(ra);
      end
      S_T6: begin
        running = 1'b1; step = 3'd6;
        Zhighout = 1'b1; HIin = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/src_control_unit.md
Name: src_control_unit

Overview:
- Hardwired control sequencer for the Mini SRC bus datapath.
- Steps the datapath through instruction fetch (T0–T2) and register-register ALU execute (T3–T6) by driving the datapath's register in/out strobes, memory read, PC increment and ALU op select.
- Decodes the IR value fed back from the datapath.
- Provides run/stop/halt control, a memory-ready stall in T1 and a retired-instruction counter for bring-up and testbenches.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- NREG, 16, number of general-purpose registers; width of R_in and R_out

Ports:
- clock  in  1  system clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins fetching when in IDLE
- stop  in  1  level; request to stop after the current instruction retires
- mem_ready  in  1  memory data valid during T1
- ir  in  32  IR register contents from datapath
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive strobes
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load strobes
- IncPC, Read  out  1 each  PC increment and memory read
- R_in  out  NREG  one-hot GP register load
- R_out  out  NREG  one-hot GP register bus drive
- alu_op  out  4  ALU operation select
- running  out  1  high in T0..T6
- halted  out  1  high in HALT
- illegal_op  out  1  sticky; set when an unsupported opcode is decoded
- step  out  3  current T-step (0..6); 0 when not running
- instr_count  out  CNT_W  retired ALU instructions

Behaviour:
- Reset and interface:
  - Reset is synchronous, active-high; single clock domain.
  - clear sampled high ⇒ next edge: state=IDLE, all strobes, R_in, R_out, alu_op, step, instr_count, illegal_op, halted = 0.
  - This applies mid-instruction too; no partial step completes.
- Strobe timing:
  - All control outputs are a Moore decode of the registered state plus ir.
  - Each strobe is asserted for exactly the cycle(s) of its T-step.
- IR field decode:
  - opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
  - Decode is valid from T3 onward; IR loads at the end of T2.
- Opcode set:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 DIV, 10 NEG, 11 NOT, 31 HALT.
  - All other opcodes are illegal.
  - alu_op = opcode[3:0] during T4; 0 otherwise.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- IDLE:
  - start=1 ⇒ T0; stop is ignored here.
- T0: PCout, MARin, IncPC, Zin ⇒ T1.
- T1: Zlowout, PCin, Read.
  - Remains in T1 while mem_ready=0, with Read held high.
  - PCin is asserted only in the first T1 cycle, so PC loads once.
  - MDRin is asserted only in the cycle where mem_ready=1; then ⇒ T2.
- T2: MDRout, IRin ⇒ T3.
- T3 (decode):
  - opcode 31 ⇒ HALT, asserting no strobes.
  - Illegal opcode ⇒ set illegal_op, go to HALT.
  - Otherwise: R_out[Rb], Yin ⇒ T4.
- T4:
  - Binary ops: R_out[Rc], Zin.
  - NEG/NOT: R_out[Rb], Zin.
  - Then ⇒ T5.
- T5:
  - MUL/DIV: Zlowout, LOin ⇒ T6.
  - Others: Zlowout, R_in[Ra] ⇒ retire.
- T6: Zhighout, HIin ⇒ retire.
- Retire:
  - instr_count+1, wrapping modulo 2^CNT_W.
  - Next state: stop=1 ⇒ IDLE, else T0.
- HALT: left only via clear; start and stop ignored.
- Invariants:
  - At most one bus-drive strobe (PCout, Zlowout, Zhighout, MDRout, any R_out bit) high in any cycle.
  - R_in and R_out are one-hot or zero.
- Misc:
  - start while running is ignored.
  - stop asserted then deasserted before retire has no effect; it is sampled only at retire.
  - Writes to R0 are permitted (no hardwired zero).
- Latency with mem_ready=1 in the first T1 cycle: ALU op 6 cycles (T0..T5); MUL/DIV 7 cycles.

Test Plan:
- Fetch/ALU timing: clear, start, ir=0x00918000 (ADD R1,R2,R3), mem_ready=1 → T0..T5 in 6 cycles; R_out=0x0004 in T3, R_out=0x0008 with alu_op=0 in T4, R_in=0x0002 in T5; instr_count=1.
- Memory stall: mem_ready low for 3 cycles → T1 lasts 4 cycles; Read high all 4; PCin in cycle 1 only; MDRin in cycle 4 only.
- MUL path: ir=0x402B0000 (MUL R5,R6) → alu_op=8 in T4, LOin in T5, HIin in T6, no R_in asserted; retire after 7 cycles.
- Halt and illegal: ir=0xF8000000 → HALT after T3 with halted=1 and start ignored. Repeat after clear with ir=0x60000000 → illegal_op=1, halted=1.
- Run control: stop asserted during T2 of the 2nd instruction → that instruction retires, then IDLE; instr_count=2; running=0.
- Mid-op clear: clear in T4 → next cycle all strobes 0, step=0, instr_count=0; a subsequent start fetches normally.
- Counter wrap: preset via 65536 retired ops, or CNT_W=4 with 16 ops → instr_count wraps to 0.
- Every case: assert the single-bus-driver invariant every cycle.
